// File: rtl/block_pkg.sv
`default_nettype none
// ============================================================================
// Module   : block_pkg
// Purpose  : Board geometry, cell encoding, shape masks and FSM states shared
//            by the board writer, renderer and piece preview.
// Revision : 1.0  initial release
// ============================================================================
package block_pkg;

    localparam int BOARD_ROWS  = 8;
    localparam int BOARD_COLS  = 8;
    localparam int CELL_W      = 3;
    localparam int SHAPE_SLOTS = 8;

    localparam logic [CELL_W-1:0] CELL_EMPTY = 3'b000;
    localparam int                CELL_OCC   = 2;

    localparam logic [1:0] COLOR_BLUE   = 2'd0;
    localparam logic [1:0] COLOR_YELLOW = 2'd1;
    localparam logic [1:0] COLOR_ORANGE = 2'd2;
    localparam logic [1:0] COLOR_RED    = 2'd3;

    // Slot k of a mask sits at row k>>2, column k&3 of the 2x4 bounding box.
    localparam logic [7:0][7:0] SHAPE_MASK_TABLE = {
        8'h71, 8'h33, 8'h01, 8'h03, 8'h4F, 8'h77, 8'h27, 8'h0F
    };

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHK_ADDR = 3'd1,
        CHK_DATA = 3'd2,
        WRITE    = 3'd3,
        DONE_OK  = 3'd4,
        DONE_REJ = 3'd5
    } state_t;

    function automatic logic [7:0] shape_mask(input logic [2:0] shape);
        return SHAPE_MASK_TABLE[shape];
    endfunction

    function automatic logic [CELL_W-1:0] make_cell(input logic [1:0] color);
        return {1'b1, color};
    endfunction

endpackage
`default_nettype wire

// File: rtl/shape_mask_rom.sv
`default_nettype none
// ============================================================================
// Module   : shape_mask_rom
// Purpose  : Combinational shape code to occupancy mask lookup with popcount.
// Revision : 1.0  initial release
// ============================================================================
module shape_mask_rom
    import block_pkg::*;
(
    input  logic [2:0] i_shape,
    output logic [7:0] o_mask,
    output logic [3:0] o_count
);

    logic [7:0] w_mask;
    logic [3:0] w_count;

    always_comb begin
        w_mask  = shape_mask(i_shape);
        w_count = 4'd0;
        for (int k = 0; k < SHAPE_SLOTS; k++) begin
            w_count = w_count + {3'b000, w_mask[k]};
        end
    end

    assign o_mask  = w_mask;
    assign o_count = w_count;

endmodule
`default_nettype wire

// File: rtl/board_writer.sv
`default_nettype none
// ============================================================================
// Module   : board_writer
// Purpose  : Places one piece on the board RAM: bounds check, occupancy scan,
//            then an all-or-nothing write, with a saturating placed-cell score.
// Revision : 1.0  initial release
// ============================================================================
module board_writer
    import block_pkg::*;
#(
    parameter  int ROWS    = BOARD_ROWS,
    parameter  int COLS    = BOARD_COLS,
    parameter  int SCORE_W = 16,
    localparam int ROW_W   = $clog2(ROWS),
    localparam int COL_W   = $clog2(COLS),
    localparam int ADDR_W  = ROW_W + COL_W
) (
    input  logic                iCLK,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [2:0]          req_shape,
    input  logic [1:0]          req_color,
    input  logic [ROW_W-1:0]    req_row,
    input  logic [COL_W-1:0]    req_col,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_we,
    output logic [CELL_W-1:0]   ram_wdata,
    input  logic [CELL_W-1:0]   ram_rdata,
    output logic                done,
    output logic                ok,
    output logic                busy,
    output logic [SCORE_W-1:0]  score
);

    state_t              r_state;
    logic [2:0]          r_slot;
    logic [7:0]          r_mask;
    logic [3:0]          r_count;
    logic [1:0]          r_color;
    logic [ROW_W-1:0]    r_row;
    logic [COL_W-1:0]    r_col;
    logic                r_req_ready;
    logic                r_busy;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic                r_ram_we;
    logic [CELL_W-1:0]   r_ram_wdata;
    logic                r_done;
    logic                r_ok;
    logic [SCORE_W-1:0]  r_score;

    logic [7:0]          w_mask;
    logic [3:0]          w_count;
    logic                w_in_bounds;
    logic [2:0]          w_next_slot;
    logic [ADDR_W-1:0]   w_next_addr;
    logic [SCORE_W:0]    w_score_sum;
    logic [SCORE_W-1:0]  w_score_next;
    logic [1:0]          w_rdata_unused;

    shape_mask_rom u_shape_rom (
        .i_shape (req_shape),
        .o_mask  (w_mask),
        .o_count (w_count)
    );

    function automatic logic [ADDR_W-1:0] slot_addr(
        input logic [ROW_W-1:0] row,
        input logic [COL_W-1:0] col,
        input logic [2:0]       slot
    );
        logic [ROW_W-1:0] row_sum;
        logic [COL_W-1:0] col_sum;
        row_sum = row + ROW_W'(slot[2]);
        col_sum = col + COL_W'(slot[1:0]);
        return {row_sum, col_sum};
    endfunction

    // Any set slot falling off the bottom or right edge rejects the piece.
    always_comb begin
        w_in_bounds = 1'b1;
        for (int k = 0; k < SHAPE_SLOTS; k++) begin
            if (w_mask[k] && ((int'(req_row) + (k >> 2)) >= ROWS ||
                              (int'(req_col) + (k & 3))  >= COLS)) begin
                w_in_bounds = 1'b0;
            end
        end
    end

    assign w_next_slot    = r_slot + 3'd1;
    assign w_next_addr    = slot_addr(r_row, r_col, w_next_slot);
    assign w_score_sum    = {1'b0, r_score} + (SCORE_W+1)'(r_count);
    assign w_score_next   = w_score_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_score_sum[SCORE_W-1:0];
    assign w_rdata_unused = ram_rdata[1:0];

    always_ff @(posedge iCLK or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_slot      <= 3'd0;
            r_mask      <= 8'd0;
            r_count     <= 4'd0;
            r_color     <= 2'd0;
            r_row       <= '0;
            r_col       <= '0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= CELL_EMPTY;
            r_done      <= 1'b0;
            r_ok        <= 1'b0;
            r_score     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_mask      <= w_mask;
                        r_count     <= w_count;
                        r_color     <= req_color;
                        r_row       <= req_row;
                        r_col       <= req_col;
                        r_slot      <= 3'd0;
                        if (w_in_bounds) begin
                            r_state    <= CHK_ADDR;
                            r_ram_addr <= {req_row, req_col};
                        end else begin
                            r_state <= DONE_REJ;
                            r_done  <= 1'b1;
                            r_ok    <= 1'b0;
                        end
                    end
                end

                // Set slots take an extra cycle so the RAM read can return.
                CHK_ADDR, CHK_DATA: begin
                    if (r_state == CHK_ADDR && r_mask[r_slot]) begin
                        r_state <= CHK_DATA;
                    end else if (r_state == CHK_DATA && ram_rdata[CELL_OCC]) begin
                        r_state <= DONE_REJ;
                        r_done  <= 1'b1;
                        r_ok    <= 1'b0;
                    end else if (r_slot == 3'd7) begin
                        r_state     <= WRITE;
                        r_slot      <= 3'd0;
                        r_ram_addr  <= {r_row, r_col};
                        r_ram_we    <= r_mask[0];
                        r_ram_wdata <= make_cell(r_color);
                    end else begin
                        r_state    <= CHK_ADDR;
                        r_slot     <= w_next_slot;
                        r_ram_addr <= w_next_addr;
                    end
                end

                WRITE: begin
                    if (r_slot == 3'd7) begin
                        r_ram_we <= 1'b0;
                        r_state  <= DONE_OK;
                        r_done   <= 1'b1;
                        r_ok     <= 1'b1;
                        r_score  <= w_score_next;
                    end else begin
                        r_slot     <= w_next_slot;
                        r_ram_addr <= w_next_addr;
                        r_ram_we   <= r_mask[w_next_slot];
                    end
                end

                DONE_OK, DONE_REJ: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end

                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_ram_we    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign busy      = r_busy;
    assign ram_addr  = r_ram_addr;
    assign ram_we    = r_ram_we;
    assign ram_wdata = r_ram_wdata;
    assign done      = r_done;
    assign ok        = r_ok;
    assign score     = r_score;

endmodule
`default_nettype wire

// File: tb/tb_board_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_board_writer
// Purpose  : Directed self-checking bench for board_writer with a board RAM model.
// Revision : 1.0  initial release
// ============================================================================
module tb_board_writer;

    logic        iCLK = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_shape;
    logic [1:0]  req_color;
    logic [2:0]  req_row;
    logic [2:0]  req_col;
    logic [5:0]  ram_addr;
    logic        ram_we;
    logic [2:0]  ram_wdata;
    logic [2:0]  ram_rdata;
    logic        done;
    logic        ok;
    logic        busy;
    logic [15:0] score;

    always #5 iCLK = ~iCLK;

    board_writer #(.ROWS(8), .COLS(8), .SCORE_W(16)) dut (
        .iCLK      (iCLK),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_shape (req_shape),
        .req_color (req_color),
        .req_row   (req_row),
        .req_col   (req_col),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .done      (done),
        .ok        (ok),
        .busy      (busy),
        .score     (score)
    );

    // Board RAM model with one-cycle read latency, plus a write and handshake log.
    logic [2:0] mem [64];
    logic       mem_clear = 1'b0;
    logic       pre_we    = 1'b0;
    logic [5:0] pre_addr  = 6'd0;
    logic [2:0] pre_data  = 3'd0;
    logic [5:0] wr_addr [64];
    logic [2:0] wr_data [64];
    int         wr_n = 0;
    int         hs_n = 0;

    always @(posedge iCLK) begin
        ram_rdata <= mem[ram_addr];
        if (mem_clear) begin
            for (int i = 0; i < 64; i++) mem[i] <= 3'd0;
        end else if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        if (ram_we) begin
            wr_addr[wr_n[5:0]] <= ram_addr;
            wr_data[wr_n[5:0]] <= ram_wdata;
            wr_n <= wr_n + 1;
        end
        if (req_valid && req_ready) hs_n <= hs_n + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_write(input string tag, input int idx, input logic [5:0] a, input logic [2:0] d);
        logic [5:0] i6;
        i6 = idx[5:0];
        check({tag, "_addr"}, 32'(wr_addr[i6]), 32'(a));
        check({tag, "_data"}, 32'(wr_data[i6]), 32'(d));
    endtask

    task automatic board_clear();
        @(negedge iCLK) mem_clear = 1'b1;
        @(negedge iCLK) mem_clear = 1'b0;
    endtask

    // Returns #1 after the transfer edge; hold keeps req_valid asserted.
    task automatic send(input logic [2:0] shape, input logic [1:0] color,
                        input logic [2:0] row, input logic [2:0] col, input bit hold);
        int waited;
        @(negedge iCLK);
        req_valid = 1'b1;
        req_shape = shape;
        req_color = color;
        req_row   = row;
        req_col   = col;
        waited    = 0;
        while (!req_ready && waited < 60) begin
            @(negedge iCLK);
            waited++;
        end
        if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
        @(posedge iCLK);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    // lat = 1 means done seen in the cycle right after the transfer edge.
    task automatic wait_done(output int lat, output int addr_moves);
        logic [5:0] a0;
        a0 = ram_addr;
        lat = -1;
        addr_moves = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge iCLK);
            if (ram_addr !== a0) addr_moves++;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, mv, n0, h0;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_shape = 3'd0;
        req_color = 2'd0;
        req_row   = 3'd0;
        req_col   = 3'd0;
        mem_clear = 1'b1;
        repeat (3) @(negedge iCLK);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_we",    32'(ram_we),    32'd0);
        check("rst_addr",  32'(ram_addr),  32'd0);
        check("rst_wdata", 32'(ram_wdata), 32'd0);
        check("rst_done",  32'(done),      32'd0);
        check("rst_ok",    32'(ok),        32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_score", 32'(score),     32'd0);
        reset     = 1'b0;
        mem_clear = 1'b0;

        // Single cell, orange, at (0,0).
        n0 = wr_n;
        send(3'd5, 2'd2, 3'd0, 3'd0, 1'b0);
        check("t1_busy", 32'(busy), 32'd1);
        wait_done(lat, mv);
        check("t1_lat",   32'(lat),   32'd18);
        check("t1_ok",    32'(ok),    32'd1);
        check("t1_score", 32'(score), 32'd1);
        @(negedge iCLK);
        check("t1_ready_after", 32'(req_ready), 32'd1);
        check("t1_busy_after",  32'(busy),      32'd0);
        check("t1_nwr", 32'(wr_n - n0), 32'd1);
        check_write("t1_w0", n0, 6'd0, 3'b110);

        // Shape 0 at (0,5) runs off the right edge.
        n0 = wr_n;
        send(3'd0, 2'd1, 3'd0, 3'd5, 1'b0);
        wait_done(lat, mv);
        check("t2_lat",      32'(lat), 32'd1);
        check("t2_ok",       32'(ok),  32'd0);
        check("t2_addr_mov", 32'(mv),  32'd0);
        @(negedge iCLK);
        check("t2_nwr",   32'(wr_n - n0), 32'd0);
        check("t2_score", 32'(score),     32'd1);

        // Occupied cell at addr 10 (slot 6 of shape 2) rejects the piece.
        board_clear();
        @(negedge iCLK);
        pre_we = 1'b1; pre_addr = 6'd10; pre_data = 3'b100;
        @(negedge iCLK);
        pre_we = 1'b0;
        n0 = wr_n;
        send(3'd2, 2'd1, 3'd0, 3'd0, 1'b0);
        wait_done(lat, mv);
        check("t3_lat", 32'(lat), 32'd14);
        check("t3_ok",  32'(ok),  32'd0);
        @(negedge iCLK);
        check("t3_nwr",   32'(wr_n - n0), 32'd0);
        check("t3_m0",    32'(mem[0]),  32'd0);
        check("t3_m1",    32'(mem[1]),  32'd0);
        check("t3_m2",    32'(mem[2]),  32'd0);
        check("t3_m8",    32'(mem[8]),  32'd0);
        check("t3_m9",    32'(mem[9]),  32'd0);
        check("t3_m10",   32'(mem[10]), 32'd4);
        check("t3_score", 32'(score),   32'd1);

        // Shape 7, red, at (6,5): bottom-right corner fit.
        board_clear();
        n0 = wr_n;
        send(3'd7, 2'd3, 3'd6, 3'd5, 1'b0);
        wait_done(lat, mv);
        check("t4_lat",   32'(lat),   32'd21);
        check("t4_ok",    32'(ok),    32'd1);
        check("t4_score", 32'(score), 32'd5);
        @(negedge iCLK);
        check("t4_nwr", 32'(wr_n - n0), 32'd4);
        check_write("t4_w0", n0 + 0, 6'd53, 3'b111);
        check_write("t4_w1", n0 + 1, 6'd61, 3'b111);
        check_write("t4_w2", n0 + 2, 6'd62, 3'b111);
        check_write("t4_w3", n0 + 3, 6'd63, 3'b111);

        // Back-to-back requests with req_valid held high.
        n0 = wr_n;
        h0 = hs_n;
        send(3'd4, 2'd0, 3'd2, 3'd0, 1'b1);
        req_shape = 3'd5; req_color = 2'd1; req_row = 3'd3; req_col = 3'd3;
        wait_done(lat, mv);
        check("t5a_lat",   32'(lat),       32'd19);
        check("t5a_ok",    32'(ok),        32'd1);
        check("t5a_ready", 32'(req_ready), 32'd0);
        check("t5a_hs",    32'(hs_n - h0), 32'd1);
        @(negedge iCLK);
        check("t5_ready_next", 32'(req_ready), 32'd1);
        check("t5_hs_mid",     32'(hs_n - h0), 32'd1);
        @(posedge iCLK);
        #1;
        req_valid = 1'b0;
        wait_done(lat, mv);
        check("t5b_lat",   32'(lat),       32'd18);
        check("t5b_ok",    32'(ok),        32'd1);
        check("t5b_hs",    32'(hs_n - h0), 32'd2);
        check("t5b_score", 32'(score),     32'd8);
        @(negedge iCLK);
        check("t5_nwr", 32'(wr_n - n0), 32'd3);
        check_write("t5_w0", n0 + 0, 6'd16, 3'b100);
        check_write("t5_w1", n0 + 1, 6'd17, 3'b100);
        check_write("t5_w2", n0 + 2, 6'd27, 3'b101);

        // Reset in the middle of CHECK for shape 6, then a fresh placement.
        board_clear();
        n0 = wr_n;
        send(3'd6, 2'd1, 3'd4, 3'd0, 1'b0);
        repeat (3) @(negedge iCLK);
        check("t6_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("t6_busy",  32'(busy),      32'd0);
        check("t6_score", 32'(score),     32'd0);
        check("t6_ready", 32'(req_ready), 32'd1);
        check("t6_we",    32'(ram_we),    32'd0);
        check("t6_addr",  32'(ram_addr),  32'd0);
        check("t6_done",  32'(done),      32'd0);
        check("t6_ok",    32'(ok),        32'd0);
        @(negedge iCLK);
        reset = 1'b0;
        check("t6_nwr_abort", 32'(wr_n - n0), 32'd0);
        send(3'd6, 2'd1, 3'd4, 3'd0, 1'b0);
        wait_done(lat, mv);
        check("t6f_lat",   32'(lat),   32'd21);
        check("t6f_ok",    32'(ok),    32'd1);
        check("t6f_score", 32'(score), 32'd4);
        @(negedge iCLK);
        check("t6f_nwr", 32'(wr_n - n0), 32'd4);
        check_write("t6f_w0", n0 + 0, 6'd32, 3'b101);
        check_write("t6f_w1", n0 + 1, 6'd33, 3'b101);
        check_write("t6f_w2", n0 + 2, 6'd40, 3'b101);
        check_write("t6f_w3", n0 + 3, 6'd41, 3'b101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/board_writer.md
Name: board_writer

Overview:
- Writer side of the board cell memory that the block renderer reads.
- Accepts one piece-placement request: shape code, colour code and grid origin.
- Bounds-checks the piece, reads the board RAM to check every covered cell, then writes all covered cells or rejects the whole piece.
- Keeps a running score of placed cells for the HUD.

Parameters:
- ROWS, 8, board rows (power of two; the address packs row above column).
- COLS, 8, board columns (power of two).
- SCORE_W, 16, score register width.

Ports:
- iCLK  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  placement request present.
- req_ready  output  1  block can accept a request this cycle.
- req_shape  input  3  shape code 0..7.
- req_color  input  2  colour code 0..3 (0 blue, 1 yellow, 2 orange, 3 red).
- req_row  input  3  origin row, top-left of the shape's 2x4 bounding box.
- req_col  input  3  origin column.
- ram_addr  output  6  board cell address = {row, col}.
- ram_we  output  1  write strobe.
- ram_wdata  output  3  cell value written.
- ram_rdata  input  3  cell read data, valid one cycle after ram_addr is presented.
- done  output  1  one-cycle pulse when a request completes.
- ok  output  1  valid with done: 1 = placed, 0 = rejected; holds until the next done.
- busy  output  1  high whenever the state machine is not in IDLE.
- score  output  SCORE_W  cells placed since reset; saturates at all-ones.

Behaviour:
- Reset (asynchronous): state IDLE, req_ready=1, ram_we=0, ram_addr=0, ram_wdata=0, done=0, ok=0, busy=0, score=0.
- Cell encoding: bit2 = occupied; bits1:0 = colour. A value of 0 means empty. A write stores {1'b1, colour}.
- Shape mask: 8 bits. Bits[3:0] are row 0, columns 0..3; bits[7:4] are row 1, columns 0..3. Slot k maps to row k>>2, column k&3.
  - 0: 0x0F
  - 1: 0x27
  - 2: 0x77
  - 3: 0x4F
  - 4: 0x03
  - 5: 0x01
  - 6: 0x33
  - 7: 0x71
- Handshake: transfer happens when req_valid and req_ready are both high (cycle T). req_ready is high only in IDLE. The shape, colour, row, column and mask are latched at T. Requests while busy are ignored.
- Bounds check at T, combinational on the latched request: any set slot with row+r >= ROWS or col+c >= COLS fails. On failure go to DONE_REJ: done=1 and ok=0 at T+1. The RAM is never touched.
- CHECK phase starts at T+1 and walks slots k = 0..7 in order.
  - CHK_ADDR: drive ram_addr for slot k, taking one cycle per slot.
  - If mask bit k is set, go to CHK_DATA for one cycle and sample ram_rdata.
  - If ram_rdata bit2 is set, go to DONE_REJ; done pulses the next cycle.
  - Unset slots advance straight to slot k+1.
  - CHECK length = 8 + popcount(mask) cycles.
- WRITE phase follows a clean CHECK: 8 cycles, one per slot. ram_we=1 only on set slots, with ram_addr and ram_wdata valid in the same cycle.
- DONE_OK: done=1, ok=1, score += popcount(mask), saturating. Then return to IDLE.
- Accepted latency: done at T + 1 + (8 + n) + 8, where n = popcount(mask). Single cell: T+18.
- From DONE, return to IDLE the next cycle. req_ready is high again one cycle after done.
- Reset mid-operation: state machine aborts immediately. Cells already written during an interrupted WRITE stay written; board clearing is the game controller's job.
- ram_we is never high outside WRITE, including during reset.

Decomposition:
- Shared package block_pkg holds:
  - board dimensions;
  - cell encoding constants (CELL_EMPTY, CELL_OCC bit);
  - colour code constants;
  - shape mask table and a function shape_mask(shape);
  - the state enum.
- block_pkg is also used by the renderer.
- One sub-module, shape_mask_rom: combinational shape-to-mask lookup plus popcount. It is shared with the piece preview logic.

Test Plan:
- Empty board; shape 5, colour 2, at (0,0), accepted at T:
  - one write, addr 0, data 3'b110;
  - done=1 and ok=1 at T+18;
  - score=1.
- Shape 0 at (0,5), out of bounds:
  - done=1 and ok=0 at T+1;
  - no ram_we, ram_addr not sequenced;
  - score unchanged.
- Preload addr 10 with 3'b100; shape 2 at (0,0):
  - reject after slot 6 data cycle, ok=0;
  - zero writes; cell values at addr 0, 1, 2, 8, 9 unchanged.
- Empty board; shape 7, colour 3, at (6,5):
  - writes 3'b111 to addr 53, 61, 62, 63, in that order;
  - done at T+21;
  - score += 4.
- req_valid held high across two back-to-back requests:
  - second request accepted only in the cycle after done;
  - no request dropped or duplicated.
- Assert reset during CHECK of shape 6:
  - all outputs return to reset values immediately, busy=0, score=0;
  - a fresh request then completes normally.
